logic_unit_pipe: RTL and testbench

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

---
 rtl/logic_unit_pkg.sv | 19 +
 rtl/logic_unit_core.sv | 27 ++
 rtl/logic_unit_pipe.sv | 125 ++++++++++++
 tb/tb_logic_unit_pipe.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared op encoding and flag bit positions for the logic unit pipeline.
package logic_unit_pkg;

   typedef enum logic [2:0] {
      OP_NOT_A = 3'd0,
      OP_NOT_B = 3'd1,
      OP_AND   = 3'd2,
      OP_OR    = 3'd3,
      OP_NAND  = 3'd4,
      OP_NOR   = 3'd5,
      OP_XOR   = 3'd6,
      OP_XNOR  = 3'd7
   } op_e;

   localparam int unsigned FLAG_ZERO     = 0;
   localparam int unsigned FLAG_ALL_ONES = 1;
   localparam int unsigned FLAG_PARITY   = 2;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational bitwise logic unit: y = f(op, a, b).
module logic_unit_core
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = '0;
      unique case (op_e'(op))
         OP_NOT_A: y = ~a;
         OP_NOT_B: y = ~b;
         OP_AND:   y = a & b;
         OP_OR:    y = a | b;
         OP_NAND:  y = ~(a & b);
         OP_NOR:   y = ~(a | b);
         OP_XOR:   y = a ^ b;
         OP_XNOR:  y = ~(a ^ b);
      endcase
   end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipeline around logic_unit_core with a transfer counter.
// Define LOGIC_UNIT_PIPE_FLAGS_EN to add the registered {parity, all_ones, zero} flags port.
module logic_unit_pipe
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [15:0]      done_count
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
   ,
   output logic [2:0]       flags
`endif
);

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   logic [2:0]       s1_op_q, s1_op_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [15:0]      done_count_q, done_count_d;
   logic [WIDTH-1:0] core_y;
   logic             advance;

   logic_unit_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .op (s1_op_q),
      .a  (s1_a_q),
      .b  (s1_b_q),
      .y  (core_y)
   );

   // Both stages move together; out_ready reaches in_ready combinationally.
   assign advance  = !out_valid_q || out_ready;
   assign in_ready = !s1_valid_q || advance;

   always_comb begin
      s1_valid_d   = s1_valid_q;
      s1_a_d       = s1_a_q;
      s1_b_d       = s1_b_q;
      s1_op_d      = s1_op_q;
      out_valid_d  = out_valid_q;
      result_d     = result_q;
      done_count_d = done_count_q;

      if (in_ready) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_a_d  = a;
            s1_b_d  = b;
            s1_op_d = op;
         end
      end

      if (advance) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            result_d = core_y;
         end
      end

      if (out_valid_q && out_ready) begin
         done_count_d = done_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_a_q       <= '0;
         s1_b_q       <= '0;
         s1_op_q      <= '0;
         out_valid_q  <= 1'b0;
         result_q     <= '0;
         done_count_q <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_a_q       <= s1_a_d;
         s1_b_q       <= s1_b_d;
         s1_op_q      <= s1_op_d;
         out_valid_q  <= out_valid_d;
         result_q     <= result_d;
         done_count_q <= done_count_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign result     = result_q;
   assign done_count = done_count_q;

`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
   logic [2:0] flags_q, flags_d;

   always_comb begin
      flags_d = flags_q;
      if (advance && s1_valid_q) begin
         flags_d[FLAG_ZERO]     = (core_y == '0);
         flags_d[FLAG_ALL_ONES] = &core_y;
         flags_d[FLAG_PARITY]   = ^core_y;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q <= '0;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign flags = flags_q;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe (WIDTH=8).
module tb_logic_unit_pipe;

   localparam int WIDTH = 8;
   localparam logic [7:0] SWEEP_EXP [8] = '{8'h0F, 8'h33, 8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3};
   localparam logic [7:0] BP_A [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  op;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  result;
   logic [15:0] done_count;
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
   logic [2:0]  flags;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   logic_unit_pipe #(
      .WIDTH (WIDTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .op         (op),
      .a          (a),
      .b          (b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .result     (result),
      .done_count (done_count)
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
      ,
      .flags      (flags)
`endif
   );

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b1; a = 8'hFF; b = 8'hFF; op = 3'd0; out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (result !== 8'h00) begin n_fail++; $display("FAIL reset_result: got %h want 00", result); end
      n_cmp++; if (done_count !== 16'h0000) begin n_fail++; $display("FAIL reset_done_count: got %h want 0000", done_count); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
      n_cmp++; if (flags !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", flags); end
`endif
      repeat (3) @(negedge clk);
      // The beat offered while rst was high must never emerge.
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_no_beat: got %b want 0", out_valid); end
   endtask

   task automatic test_op_sweep;
      logic [15:0] cnt0;
      cnt0 = done_count;
      out_ready = 1'b1; a = 8'hF0; b = 8'hCC;
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) begin
            in_valid = 1'b1; op = 3'(i);
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL sweep_in_ready[%0d]: got %b want 1", i, in_ready); end
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (i == 0) begin
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sweep_latency_early: got %b want 0", out_valid); end
         end else begin
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sweep_out_valid[%0d]: got %b want 1", i - 1, out_valid); end
            n_cmp++; if (result !== SWEEP_EXP[i-1]) begin n_fail++; $display("FAIL sweep_result[%0d]: got %h want %h", i - 1, result, SWEEP_EXP[i-1]); end
         end
      end
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sweep_drain: got %b want 0", out_valid); end
      n_cmp++; if (done_count !== cnt0 + 16'd8) begin n_fail++; $display("FAIL sweep_count: got %h want %h", done_count, cnt0 + 16'd8); end
   endtask

   task automatic test_backpressure;
      logic [15:0] cnt0;
      int idx;
      int o;
      logic acc;
      cnt0 = done_count;
      out_ready = 1'b0; in_valid = 1'b1; op = 3'd3; b = 8'h00; a = BP_A[0];
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept0: got %b want 1", in_ready); end
      @(negedge clk);
      a = BP_A[1];
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept1: got %b want 1", in_ready); end
      @(negedge clk);
      a = BP_A[2];
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_in_ready[%0d]: got %b want 0", k, in_ready); end
         n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stall_out_valid[%0d]: got %b want 1", k, out_valid); end
         n_cmp++; if (result !== 8'h11) begin n_fail++; $display("FAIL bp_stall_result[%0d]: got %h want 11", k, result); end
         @(negedge clk);
      end
      out_ready = 1'b1;
      idx = 2;
      o = 0;
      for (int c = 0; c < 20 && o < 4; c++) begin
         in_valid = (idx < 4);
         if (idx < 4) a = BP_A[idx];
         #1;
         if (out_valid) begin
            n_cmp++; if (result !== BP_A[o]) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", o, result, BP_A[o]); end
            o++;
         end
         acc = in_valid && in_ready;
         @(negedge clk);
         if (acc) idx++;
      end
      in_valid = 1'b0;
      n_cmp++; if (o !== 4) begin n_fail++; $display("FAIL bp_drain_budget: got %0d beats want 4", o); end
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got %b want 0", out_valid); end
      n_cmp++; if (done_count !== cnt0 + 16'd4) begin n_fail++; $display("FAIL bp_count: got %h want %h", done_count, cnt0 + 16'd4); end
   endtask

`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
   task automatic test_flags;
      out_ready = 1'b1; in_valid = 1'b1; a = 8'h5A; b = 8'h5A; op = 3'd6;
      @(negedge clk);
      op = 3'd7;
      @(negedge clk);
      in_valid = 1'b0;
      n_cmp++; if (result !== 8'h00) begin n_fail++; $display("FAIL flags_xor_result: got %h want 00", result); end
      n_cmp++; if (flags !== 3'b001) begin n_fail++; $display("FAIL flags_xor: got %b want 001", flags); end
      @(negedge clk);
      n_cmp++; if (result !== 8'hFF) begin n_fail++; $display("FAIL flags_xnor_result: got %h want FF", result); end
      n_cmp++; if (flags !== 3'b010) begin n_fail++; $display("FAIL flags_xnor: got %b want 010", flags); end
      @(negedge clk);
   endtask
`endif

   task automatic test_reset_mid;
      out_ready = 1'b0; in_valid = 1'b1; op = 3'd2; a = 8'hAA; b = 8'hFF;
      @(negedge clk);
      a = 8'h55;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_in_flight: got %b want 1", out_valid); end
      // rst must win over the handshakes offered in the same cycle.
      rst = 1'b1; out_ready = 1'b1; a = 8'h77;
      @(negedge clk);
      rst = 1'b0; in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (done_count !== 16'h0000) begin n_fail++; $display("FAIL mid_done_count: got %h want 0000", done_count); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_no_emerge[%0d]: got %b want 0", k, out_valid); end
      end
   endtask

   task automatic test_counter_wrap;
      out_ready = 1'b1; op = 3'd0; a = 8'h00; b = 8'h00;
      for (int i = 0; i <= 65538; i++) begin
         in_valid = (i < 65537);
         @(negedge clk);
         if (i == 65536) begin
            n_cmp++; if (done_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_ffff: got %h want FFFF", done_count); end
         end
         if (i == 65537) begin
            n_cmp++; if (done_count !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %h want 0000", done_count); end
         end
      end
      @(negedge clk);
      n_cmp++; if (done_count !== 16'h0001) begin n_fail++; $display("FAIL wrap_final: got %h want 0001", done_count); end
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_drain: got %b want 0", out_valid); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = 3'd0; a = 8'h00; b = 8'h00;
      @(negedge clk);
      test_reset();
      test_op_sweep();
      test_backpressure();
`ifdef LOGIC_UNIT_PIPE_FLAGS_EN
      test_flags();
`endif
      test_reset_mid();
      test_counter_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
